instr_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decode/execute block. It owns the fetch PC and issues word reads to instruction memory over a req/ack handshake. Fetched words are buffered in a small FIFO together with their PCs, then presented to decode as I_OUT with a valid/ready handshake. Decode can redirect fetch after a BEQ or JUMP resolves; the redirect flushes the buffer and discards any in-flight fetch.

---
 rtl/instr_fetch_unit.sv | 187 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads instruction memory over req/ack,
// and buffers words with their PCs for decode. Optional counters under IF_PERF_EN.
module instr_fetch_unit #(
  parameter int unsigned          WORD_SIZE = 16,
  parameter int unsigned          ADDR_SIZE = 16,
  parameter int unsigned          DEPTH     = 2,
  parameter logic [ADDR_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 DCLK,
  input  logic                 RST,
  output logic                 IM_REQ,
  output logic [ADDR_SIZE-1:0] IM_ADDR,
  input  logic                 IM_ACK,
  input  logic [WORD_SIZE-1:0] IM_RDATA,
  output logic [WORD_SIZE-1:0] I_OUT,
  output logic [ADDR_SIZE-1:0] PC_OUT,
  output logic                 I_VALID,
  input  logic                 I_READY,
  input  logic                 REDIRECT,
  input  logic [ADDR_SIZE-1:0] REDIRECT_PC
`ifdef IF_PERF_EN
  ,
  output logic [15:0]          FETCH_CNT,
  output logic [15:0]          DROP_CNT
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {S_IDLE, S_REQ} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic                   req_q, req_d;
  logic                   drop_q, drop_d;
  logic                   valid_q, valid_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [WORD_SIZE-1:0]   word_q [DEPTH];
  logic [WORD_SIZE-1:0]   word_d [DEPTH];
  logic [ADDR_SIZE-1:0]   pc_q   [DEPTH];
  logic [ADDR_SIZE-1:0]   pc_d   [DEPTH];

  logic xfer_c, pop_c, push_c;

  assign xfer_c = req_q & IM_ACK;
  assign pop_c  = valid_q & I_READY;
  assign push_c = xfer_c & ~drop_q & ~REDIRECT;

  // Shift-register FIFO: slot 0 is always the head, unused slots hold zero.
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      word_d[i] = word_q[i];
      pc_d[i]   = pc_q[i];
    end
    if (REDIRECT) begin
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_d[i] = '0;
        pc_d[i]   = '0;
      end
    end else begin
      if (pop_c) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          word_d[i] = word_q[i+1];
          pc_d[i]   = pc_q[i+1];
        end
        word_d[DEPTH-1] = '0;
        pc_d[DEPTH-1]   = '0;
        count_d         = count_q - CNT_W'(1);
      end
      if (push_c) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == count_d) begin
            word_d[i] = IM_RDATA;
            pc_d[i]   = addr_q;
          end
        end
        count_d = count_d + CNT_W'(1);
      end
    end
    valid_d = (count_d != '0);
  end

  // Fetch PC, drop flag, and request issue; issue sees post-pop/push occupancy.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    req_d      = req_q;
    addr_d     = addr_q;

    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase

    if (REDIRECT) begin
      fetch_pc_d = REDIRECT_PC;
    end else if (push_c) begin
      fetch_pc_d = ADDR_SIZE'(addr_q + ADDR_SIZE'(1));
    end

    if (xfer_c) begin
      drop_d = 1'b0;
    end else if (REDIRECT && req_q) begin
      drop_d = 1'b1;
    end

    if (req_q && !IM_ACK) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else begin
      req_d  = (state_d == S_REQ) && (count_d < CNT_W'(DEPTH));
      addr_d = fetch_pc_d;
    end
  end

  always_ff @(posedge DCLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      drop_q     <= 1'b0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      drop_q     <= drop_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= word_d[i];
        pc_q[i]   <= pc_d[i];
      end
    end
  end

  assign IM_REQ  = req_q;
  assign IM_ADDR = addr_q;
  assign I_OUT   = word_q[0];
  assign PC_OUT  = pc_q[0];
  assign I_VALID = valid_q;

`ifdef IF_PERF_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] drop_inc_c;

  // Discards are flushed entries plus any response thrown away this cycle.
  always_comb begin
    drop_inc_c = '0;
    if (REDIRECT) begin
      drop_inc_c = 16'(count_q);
    end
    if (xfer_c && (drop_q || REDIRECT)) begin
      drop_inc_c = drop_inc_c + 16'd1;
    end
    drop_cnt_d  = drop_cnt_q + drop_inc_c;
    fetch_cnt_d = fetch_cnt_q + 16'(pop_c && !REDIRECT);
  end

  always_ff @(posedge DCLK) begin
    if (RST) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign FETCH_CNT = fetch_cnt_q;
  assign DROP_CNT  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit; memory returns 16'h1000 + address.
module tb_instr_fetch_unit;

  logic        DCLK;
  logic        RST;
  logic        IM_REQ;
  logic [15:0] IM_ADDR;
  logic        IM_ACK;
  logic [15:0] IM_RDATA;
  logic [15:0] I_OUT;
  logic [15:0] PC_OUT;
  logic        I_VALID;
  logic        I_READY;
  logic        REDIRECT;
  logic [15:0] REDIRECT_PC;
`ifdef IF_PERF_EN
  logic [15:0] FETCH_CNT;
  logic [15:0] DROP_CNT;
`endif

  instr_fetch_unit dut (
    .DCLK        (DCLK),
    .RST         (RST),
    .IM_REQ      (IM_REQ),
    .IM_ADDR     (IM_ADDR),
    .IM_ACK      (IM_ACK),
    .IM_RDATA    (IM_RDATA),
    .I_OUT       (I_OUT),
    .PC_OUT      (PC_OUT),
    .I_VALID     (I_VALID),
    .I_READY     (I_READY),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC)
`ifdef IF_PERF_EN
    ,
    .FETCH_CNT   (FETCH_CNT),
    .DROP_CNT    (DROP_CNT)
`endif
  );

  initial DCLK = 1'b0;
  always #5 DCLK = ~DCLK;

  typedef struct {
    logic        ready;
    logic        ack;
    logic        redir;
    logic [15:0] rpc;
    int          rep;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_iout;
    logic [15:0] e_pc;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic rd, logic ak, logic rx, logic [15:0] rpc, int rep,
                              logic ereq, logic [15:0] eaddr, logic ev,
                              logic [15:0] eout, logic [15:0] epc);
    vec_t v;
    v.ready = rd; v.ack = ak; v.redir = rx; v.rpc = rpc; v.rep = rep;
    v.e_req = ereq; v.e_addr = eaddr; v.e_valid = ev; v.e_iout = eout; v.e_pc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic ereq, input logic [15:0] eaddr,
                             input logic ev, input logic [15:0] eout, input logic [15:0] epc);
    chk({tag, " IM_REQ"},  16'(IM_REQ),  16'(ereq));
    chk({tag, " IM_ADDR"}, IM_ADDR,      eaddr);
    chk({tag, " I_VALID"}, 16'(I_VALID), 16'(ev));
    chk({tag, " I_OUT"},   I_OUT,        eout);
    chk({tag, " PC_OUT"},  PC_OUT,       epc);
  endtask

  // Inputs change on the falling edge; the memory acks only a live request.
  task automatic drive(input logic rd, input logic ak, input logic rx, input logic [15:0] rpc);
    I_READY     = rd;
    REDIRECT    = rx;
    REDIRECT_PC = rpc;
    IM_ACK      = ak & IM_REQ;
    IM_RDATA    = IM_ADDR + 16'h1000;
  endtask

  initial begin
    //         rdy ack rdr rpc       rep req addr      v  i_out     pc_out
    tbl.push_back(mk(1, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000)); // 0 reset state
    tbl.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000)); // 1 first request
    tbl.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'h0001, 1, 16'h1000, 16'h0000)); // 2 streaming
    tbl.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'h0002, 1, 16'h1001, 16'h0001)); // 3
    tbl.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 16'h0003, 1, 16'h1002, 16'h0002)); // 4 stall decode
    tbl.push_back(mk(0, 1, 0, 16'h0000, 9, 0, 16'h0004, 1, 16'h1002, 16'h0002)); // 5 full, no request
    tbl.push_back(mk(1, 1, 0, 16'h0000, 1, 0, 16'h0004, 1, 16'h1002, 16'h0002)); // 6 resume
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 16'h0004, 1, 16'h1003, 16'h0003)); // 7 memory waits
    tbl.push_back(mk(1, 0, 1, 16'h0040, 1, 1, 16'h0004, 0, 16'h0000, 16'h0000)); // 8 redirect in flight
    tbl.push_back(mk(1, 0, 0, 16'h0000, 2, 1, 16'h0004, 0, 16'h0000, 16'h0000)); // 9 address held
    tbl.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'h0004, 0, 16'h0000, 16'h0000)); // 10 dropped ack
    tbl.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'h0040, 0, 16'h0000, 16'h0000)); // 11 target issued
    tbl.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'h0041, 1, 16'h1040, 16'h0040)); // 12
    tbl.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 16'h0042, 1, 16'h1041, 16'h0041)); // 13 fill
    tbl.push_back(mk(1, 1, 0, 16'h0000, 1, 0, 16'h0043, 1, 16'h1041, 16'h0041)); // 14 full + pop
    tbl.push_back(mk(1, 1, 1, 16'hFFFE, 1, 1, 16'h0043, 1, 16'h1042, 16'h0042)); // 15 redirect+ack+pop
    tbl.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'hFFFE, 0, 16'h0000, 16'h0000)); // 16
    tbl.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'hFFFF, 1, 16'h0FFE, 16'hFFFE)); // 17
    tbl.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'h0000, 1, 16'h0FFF, 16'hFFFF)); // 18 PC wrap
    tbl.push_back(mk(0, 0, 1, 16'h0100, 1, 1, 16'h0001, 1, 16'h1000, 16'h0000)); // 19 redirect, pending
    tbl.push_back(mk(0, 0, 1, 16'h0200, 1, 1, 16'h0001, 0, 16'h0000, 16'h0000)); // 20 second redirect
    tbl.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 16'h0001, 0, 16'h0000, 16'h0000)); // 21 dropped ack
    tbl.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 16'h0200, 0, 16'h0000, 16'h0000)); // 22 latest target
    tbl.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 16'h0201, 1, 16'h1200, 16'h0200)); // 23
    tbl.push_back(mk(0, 0, 1, 16'h0300, 1, 0, 16'h0202, 1, 16'h1200, 16'h0200)); // 24 redirect, idle bus
    tbl.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'h0300, 0, 16'h0000, 16'h0000)); // 25
    tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 16'h0301, 1, 16'h1300, 16'h0300)); // 26

    RST = 1'b1;
    drive(0, 0, 0, 16'h0000);
    repeat (3) @(posedge DCLK);
    @(negedge DCLK);
    RST = 1'b0;

    for (int r = 0; r < tbl.size(); r++) begin
      for (int k = 0; k < tbl[r].rep; k++) begin
        chk_outputs($sformatf("row%0d.%0d", r, k), tbl[r].e_req, tbl[r].e_addr,
                    tbl[r].e_valid, tbl[r].e_iout, tbl[r].e_pc);
        drive(tbl[r].ready, tbl[r].ack, tbl[r].redir, tbl[r].rpc);
        @(negedge DCLK);
      end
    end

`ifdef IF_PERF_EN
    chk("perf FETCH_CNT", FETCH_CNT, 16'd8);
    chk("perf DROP_CNT",  DROP_CNT,  16'd7);
`endif

    // Reset while a request is outstanding abandons it.
    RST = 1'b1;
    drive(0, 0, 0, 16'h0000);
    @(negedge DCLK);
    chk_outputs("midreset", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
`ifdef IF_PERF_EN
    chk("midreset FETCH_CNT", FETCH_CNT, 16'd0);
    chk("midreset DROP_CNT",  DROP_CNT,  16'd0);
`endif
    RST = 1'b0;
    drive(1, 1, 0, 16'h0000);
    @(negedge DCLK);
    chk_outputs("restart req", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    drive(1, 1, 0, 16'h0000);
    @(negedge DCLK);
    chk_outputs("restart data", 1'b1, 16'h0001, 1'b1, 16'h1000, 16'h0000);
    drive(0, 0, 0, 16'h0000);
    @(negedge DCLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
